// File: rtl/spi3_arb_if.sv
// Bus bundle for spi3_arb_master: requester handshake, read-data return and the
// SPI pins. Signal names follow the board-level pin list.
interface spi3_arb_if #(
  parameter int C_DAT_W = 8
);
  // REQ/ACK handshake: a requester raises REQs_i[n] (level) with WDATs_i stable,
  // holds it until the one-cycle ACKs_o[n] pulse, and drops it the cycle after.
  // RDATs_o is valid from the ACK cycle and held until the next ACK.
  logic [2:0]           REQs_i;
  logic [3*C_DAT_W-1:0] WDATs_i;
  logic [2:0]           ACKs_o;
  logic [C_DAT_W-1:0]   RDATs_o;
  logic [2:0]           GNTs_o;
  logic                 BUSY_o;
  logic                 SCLK_o;
  logic                 COPI_o;
  logic                 XSS_0_o;
  logic                 XSS_1_o;
  logic                 XSS_2_o;
  logic                 CIPO_0_i;
  logic                 CIPO_1_i;
  logic                 CIPO_2_i;
  logic [2:0]           dbg_state;

  modport master (
    input  REQs_i, WDATs_i, CIPO_0_i, CIPO_1_i, CIPO_2_i,
    output ACKs_o, RDATs_o, GNTs_o, BUSY_o, SCLK_o, COPI_o,
    output XSS_0_o, XSS_1_o, XSS_2_o, dbg_state
  );

  modport slave (
    output REQs_i, WDATs_i, CIPO_0_i, CIPO_1_i, CIPO_2_i,
    input  ACKs_o, RDATs_o, GNTs_o, BUSY_o, SCLK_o, COPI_o,
    input  XSS_0_o, XSS_1_o, XSS_2_o, dbg_state
  );
endinterface

// File: rtl/spi3_arb_master.sv
// Round-robin SPI mode-0 master shared by three requesters, one chip select
// and one CIPO per target, MSB first, full duplex.
module spi3_arb_master #(
  parameter int C_DAT_W    = 8,
  parameter int C_HALF_DIV = 68
) (
  input  logic       CK_i,
  input  logic       RST_i,
  spi3_arb_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

  localparam int HW = (C_HALF_DIV > 1) ? $clog2(C_HALF_DIV) : 1;
  localparam int EW = $clog2(2 * C_DAT_W);
  localparam logic [HW-1:0] H_LAST = HW'(C_HALF_DIV - 1);
  localparam logic [EW-1:0] E_LAST = EW'(2 * C_DAT_W - 1);

  state_t             state_q, state_d;
  logic [HW-1:0]      hcnt_q;
  logic [EW-1:0]      e_q;
  logic [1:0]         last_q, owner_q, win;
  logic [C_DAT_W-1:0] tx_q, rx_q, rdat_q, wsel;
  logic               sclk_q, copi_q;
  logic [2:0]         xss_q, ack_q, gnt_q;
  logic               tick, start, found, cipo_sel;

  assign tick = (hcnt_q == H_LAST);

  // Search order LAST+1, LAST+2, LAST; iterating backwards lets the
  // highest-priority candidate overwrite the others.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (bus.REQs_i[(int'(last_q) + 1 + k) % 3]) begin
        win   = 2'((int'(last_q) + 1 + k) % 3);
        found = 1'b1;
      end
    end
  end

  assign start = (state_q == S_IDLE) && (ack_q == 3'b000) && found;
  assign wsel  = bus.WDATs_i[32'(win) * C_DAT_W +: C_DAT_W];

  always_comb begin
    cipo_sel = 1'b0;
    case (owner_q)
      2'd0:    cipo_sel = bus.CIPO_0_i;
      2'd1:    cipo_sel = bus.CIPO_1_i;
      2'd2:    cipo_sel = bus.CIPO_2_i;
      default: cipo_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LEAD;
      S_LEAD:  if (tick) state_d = S_SHIFT;
      S_SHIFT: if (tick && e_q == E_LAST) state_d = S_TRAIL;
      S_TRAIL: if (tick) state_d = S_GAP;
      S_GAP:   if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      hcnt_q  <= '0;
      e_q     <= '0;
      last_q  <= 2'd2;
      owner_q <= 2'd0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdat_q  <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      xss_q   <= 3'b111;
      ack_q   <= 3'b000;
      gnt_q   <= 3'b000;
    end else begin
      ack_q <= 3'b000;
      // Half-period timer restarts on every state change and at each tick.
      if (state_q == S_IDLE || state_d != state_q || tick) hcnt_q <= '0;
      else                                                 hcnt_q <= hcnt_q + HW'(1);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q    <= wsel;
            copi_q  <= wsel[C_DAT_W-1];
            owner_q <= win;
            last_q  <= win;
            gnt_q   <= 3'b001 << win;
            xss_q   <= ~(3'b001 << win);
            e_q     <= '0;
          end
        end
        S_SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            e_q    <= e_q + EW'(1);
            if (!sclk_q) begin
              rx_q <= {rx_q[C_DAT_W-2:0], cipo_sel};
            end else begin
              tx_q   <= {tx_q[C_DAT_W-2:0], 1'b0};
              copi_q <= tx_q[C_DAT_W-2];
            end
          end
        end
        S_TRAIL: if (tick) xss_q <= 3'b111;
        S_GAP: begin
          if (tick) begin
            rdat_q <= rx_q;
            ack_q  <= gnt_q;
            gnt_q  <= 3'b000;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ACKs_o    = ack_q;
  assign bus.RDATs_o   = rdat_q;
  assign bus.GNTs_o    = gnt_q;
  assign bus.BUSY_o    = (state_q != S_IDLE);
  assign bus.SCLK_o    = sclk_q;
  assign bus.COPI_o    = copi_q;
  assign bus.XSS_0_o   = xss_q[0];
  assign bus.XSS_1_o   = xss_q[1];
  assign bus.XSS_2_o   = xss_q[2];
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_spi3_arb_master.sv
// Bench for spi3_arb_master: H=2 instance for arbitration/data tests and an
// H=1 instance for the fast-clock case, with a mode-0 slave model per target.
module tb_spi3_arb_master;
  localparam int W = 8;

  // clock / reset
  logic CK_i = 1'b0;
  logic rst  = 1'b1;
  always #5 CK_i = ~CK_i;

  spi3_arb_if #(.C_DAT_W(W)) ifa ();
  spi3_arb_if #(.C_DAT_W(W)) ifb ();

  spi3_arb_master #(.C_DAT_W(W), .C_HALF_DIV(2)) dut_a (.CK_i(CK_i), .RST_i(rst), .bus(ifa.master));
  spi3_arb_master #(.C_DAT_W(W), .C_HALF_DIV(1)) dut_b (.CK_i(CK_i), .RST_i(rst), .bus(ifb.master));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] wdat [3];
  logic [W-1:0] slave_val [3];
  logic [2:0]   noise_mask = 3'b000;
  logic [W-1:0] exp_q [$];
  int           exp_gnt_q [$];

  // monitor / slave state, sampled on the falling clock edge
  int         sidx [3] = '{0, 0, 0};
  logic [2:0] prev_xss = 3'b111;
  logic       prev_sclk = 1'b0;
  logic [W-1:0] copi_cap = '0;
  int copi_n = 0, xss0_low = 0, xss12_low = 0, gnt_viol = 0, ack_cnt = 0;

  always @(negedge CK_i) begin
    logic [2:0] xs;
    xs = {ifa.XSS_2_o, ifa.XSS_1_o, ifa.XSS_0_o};
    if ((prev_xss & ~xs) != 3'b000) begin
      copi_cap = '0;
      copi_n   = 0;
    end
    if (!prev_sclk && ifa.SCLK_o) begin
      copi_cap = {copi_cap[W-2:0], ifa.COPI_o};
      copi_n++;
    end
    if (!ifa.XSS_0_o) xss0_low++;
    if (!ifa.XSS_1_o || !ifa.XSS_2_o) xss12_low++;
    if (xs != 3'b111 && ifa.GNTs_o !== ~xs) gnt_viol++;
    if ($countones(ifa.GNTs_o) > 1) gnt_viol++;
    if (ifa.ACKs_o != 3'b000) ack_cnt++;
    for (int n = 0; n < 3; n++) begin
      if (prev_xss[n] && !xs[n]) sidx[n] = 0;
      else if (!xs[n] && prev_sclk && !ifa.SCLK_o) sidx[n]++;
    end
    ifa.CIPO_0_i = noise_mask[0] ? 1'($urandom) : (sidx[0] < W ? slave_val[0][W-1-sidx[0]] : 1'b0);
    ifa.CIPO_1_i = noise_mask[1] ? 1'($urandom) : (sidx[1] < W ? slave_val[1][W-1-sidx[1]] : 1'b0);
    ifa.CIPO_2_i = noise_mask[2] ? 1'($urandom) : (sidx[2] < W ? slave_val[2][W-1-sidx[2]] : 1'b0);
    prev_xss  = xs;
    prev_sclk = ifa.SCLK_o;
  end

  // reference arbitration rule: first requester from LAST+1, LAST+2, LAST
  function automatic int rr_pick(input int last, input logic [2:0] r);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (last + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic drive_req(input logic [2:0] r);
    ifa.REQs_i  = r;
    ifa.WDATs_i = {wdat[2], wdat[1], wdat[0]};
  endtask

  task automatic wait_ack(output int n, output logic timed_out);
    n = 0;
    timed_out = 1'b1;
    while (n < 2000) begin
      @(posedge CK_i); #1;
      n++;
      if (ifa.ACKs_o != 3'b000) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin wdat[n] = '0; slave_val[n] = '0; end
    drive_req(3'b000);
    ifb.REQs_i = 3'b000; ifb.WDATs_i = '0;
    ifb.CIPO_0_i = 1'b0; ifb.CIPO_1_i = 1'b0; ifb.CIPO_2_i = 1'b1;
    repeat (3) @(posedge CK_i);
    #1 rst = 1'b0;
    checks++; if (ifa.ACKs_o !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", ifa.ACKs_o); end
    checks++; if (ifa.RDATs_o !== 8'h00) begin errors++; $display("FAIL reset_rdat: got %h want 00", ifa.RDATs_o); end
    checks++; if (ifa.GNTs_o !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", ifa.GNTs_o); end
    checks++; if (ifa.BUSY_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifa.BUSY_o); end
    checks++; if ({ifa.SCLK_o, ifa.COPI_o} !== 2'b00) begin errors++; $display("FAIL reset_sclk_copi: got %b want 00", {ifa.SCLK_o, ifa.COPI_o}); end
    checks++; if ({ifa.XSS_2_o, ifa.XSS_1_o, ifa.XSS_0_o} !== 3'b111) begin errors++; $display("FAIL reset_xss: got %b want 111", {ifa.XSS_2_o, ifa.XSS_1_o, ifa.XSS_0_o}); end
  endtask

  task automatic test_basic();
    int n; logic to;
    wdat[0] = 8'hA5; slave_val[0] = 8'h3C;
    xss0_low = 0; xss12_low = 0;
    @(posedge CK_i); #1 drive_req(3'b001);
    wait_ack(n, to);
    drive_req(3'b000);
    checks++; if (to || n != 39) begin errors++; $display("FAIL basic_ack_time: got %0d cycles want 39", n); end
    checks++; if (ifa.ACKs_o !== 3'b001) begin errors++; $display("FAIL basic_ack: got %b want 001", ifa.ACKs_o); end
    checks++; if (ifa.RDATs_o !== 8'h3C) begin errors++; $display("FAIL basic_rdat: got %h want 3c", ifa.RDATs_o); end
    checks++; if (copi_cap !== 8'hA5 || copi_n != 8) begin errors++; $display("FAIL basic_copi: got %h/%0d bits want a5/8", copi_cap, copi_n); end
    checks++; if (xss0_low != 36) begin errors++; $display("FAIL basic_xss0_len: got %0d want 36", xss0_low); end
    checks++; if (xss12_low != 0) begin errors++; $display("FAIL basic_xss12: got %0d low cycles want 0", xss12_low); end
    @(posedge CK_i); #1;
    checks++; if (ifa.ACKs_o !== 3'b000 || ifa.BUSY_o !== 1'b0) begin errors++; $display("FAIL basic_ack_pulse: got ack %b busy %b want 000/0", ifa.ACKs_o, ifa.BUSY_o); end
  endtask

  // serve pending requests (with optional random new arrivals) against the model
  task automatic serve(input string tag, inout int last_m, inout logic [2:0] pend,
                       input int count, input logic hold, input logic add_random);
    int n, exp_id; logic to; logic [2:0] add;
    for (int i = 0; i < count; i++) begin
      if (add_random) begin
        add = 3'($urandom_range(1, 7)) & ~pend;
        for (int k = 0; k < 3; k++) if (add[k]) begin
          wdat[k] = 8'($urandom_range(0, 255));
          slave_val[k] = 8'($urandom_range(0, 255));
        end
        pend = pend | add;
      end
      if (pend == 3'b000) break;
      drive_req(pend);
      exp_id = rr_pick(last_m, pend);
      exp_gnt_q.push_back(exp_id);
      exp_q.push_back(slave_val[exp_id]);
      wait_ack(n, to);
      exp_id = exp_gnt_q.pop_front();
      checks++; if (to || ifa.ACKs_o !== 3'(1 << exp_id)) begin errors++; $display("FAIL %s_grant%0d: got ack %b want %b", tag, i, ifa.ACKs_o, 3'(1 << exp_id)); end
      checks++; if (ifa.RDATs_o !== exp_q[0]) begin errors++; $display("FAIL %s_rdat%0d: got %h want %h", tag, i, ifa.RDATs_o, exp_q[0]); end
      checks++; if (copi_cap !== wdat[exp_id]) begin errors++; $display("FAIL %s_copi%0d: got %h want %h", tag, i, copi_cap, wdat[exp_id]); end
      void'(exp_q.pop_front());
      last_m = exp_id;
      if (!hold) begin
        pend[exp_id] = 1'b0;
        drive_req(pend);
      end
    end
  endtask

  task automatic test_round_robin(inout int last_m);
    logic [2:0] pend;
    for (int k = 0; k < 3; k++) begin
      wdat[k] = 8'($urandom_range(0, 255)); slave_val[k] = 8'($urandom_range(0, 255));
    end
    gnt_viol = 0;
    pend = 3'b111;
    serve("rr3", last_m, pend, 3, 1'b0, 1'b0);
    pend = 3'b101;
    serve("rr02", last_m, pend, 2, 1'b0, 1'b0);
    checks++; if (gnt_viol != 0) begin errors++; $display("FAIL rr_gnt_onehot: got %0d violations want 0", gnt_viol); end
  endtask

  task automatic test_alternate(inout int last_m);
    logic [2:0] pend;
    pend = 3'b010;
    serve("alt_pre", last_m, pend, 1, 1'b0, 1'b0);
    pend = 3'b110;
    serve("alt", last_m, pend, 4, 1'b1, 1'b0);
    drive_req(3'b000);
  endtask

  task automatic test_random(inout int last_m);
    logic [2:0] pend;
    pend = 3'b000;
    serve("rand", last_m, pend, 6, 1'b0, 1'b1);
    serve("drain", last_m, pend, 3, 1'b0, 1'b0);
  endtask

  task automatic test_cipo_isolation(inout int last_m);
    int n; logic to;
    wdat[0] = 8'($urandom_range(0, 255)); slave_val[0] = 8'h00;
    noise_mask = 3'b110;
    @(posedge CK_i); #1 drive_req(3'b001);
    wait_ack(n, to);
    drive_req(3'b000);
    noise_mask = 3'b000;
    last_m = 0;
    checks++; if (to || ifa.ACKs_o !== 3'b001 || ifa.RDATs_o !== 8'h00) begin errors++; $display("FAIL iso_rdat: got ack %b rdat %h want 001/00", ifa.ACKs_o, ifa.RDATs_o); end
  endtask

  task automatic test_reset_mid();
    int n, e, acks_before; logic ps, to;
    wdat[0] = 8'($urandom_range(0, 255)); slave_val[0] = 8'($urandom_range(0, 255));
    @(posedge CK_i); #1 drive_req(3'b001);
    n = 0; e = 0; ps = 1'b0;
    while (e < 5 && n < 500) begin
      @(posedge CK_i); #1; n++;
      if (ifa.SCLK_o !== ps) begin e++; ps = ifa.SCLK_o; end
    end
    checks++; if (e != 5) begin errors++; $display("FAIL rstmid_reach_e5: got %0d edges want 5", e); end
    rst = 1'b1; drive_req(3'b000);
    @(posedge CK_i); #1 rst = 1'b0;
    checks++; if ({ifa.XSS_2_o, ifa.XSS_1_o, ifa.XSS_0_o, ifa.SCLK_o, ifa.BUSY_o} !== 5'b11100) begin errors++; $display("FAIL rstmid_outputs: got xss/sclk/busy %b want 11100", {ifa.XSS_2_o, ifa.XSS_1_o, ifa.XSS_0_o, ifa.SCLK_o, ifa.BUSY_o}); end
    checks++; if (ifa.GNTs_o !== 3'b000 || ifa.RDATs_o !== 8'h00) begin errors++; $display("FAIL rstmid_gnt_rdat: got %b/%h want 000/00", ifa.GNTs_o, ifa.RDATs_o); end
    acks_before = ack_cnt;
    repeat (100) @(posedge CK_i);
    #1;
    checks++; if (ack_cnt != acks_before) begin errors++; $display("FAIL rstmid_no_ack: got %0d acks want 0", ack_cnt - acks_before); end
    wdat[2] = 8'($urandom_range(0, 255)); slave_val[2] = 8'($urandom_range(0, 255));
    drive_req(3'b100);
    wait_ack(n, to);
    drive_req(3'b000);
    checks++; if (to || n != 39 || ifa.ACKs_o !== 3'b100) begin errors++; $display("FAIL rstmid_fresh: got %0d cycles ack %b want 39/100", n, ifa.ACKs_o); end
    checks++; if (ifa.RDATs_o !== slave_val[2] || copi_cap !== wdat[2]) begin errors++; $display("FAIL rstmid_fresh_data: got rdat %h copi %h want %h/%h", ifa.RDATs_o, copi_cap, slave_val[2], wdat[2]); end
  endtask

  task automatic test_h1();
    int n, toggles, first_t, last_t; logic ps, got;
    ifb.WDATs_i = {8'hFF, 8'h00, 8'h00};
    @(posedge CK_i); #1 ifb.REQs_i = 3'b100;
    n = 0; toggles = 0; first_t = -1; last_t = -1; ps = ifb.SCLK_o; got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge CK_i); #1; n++;
      if (ifb.SCLK_o !== ps) begin
        toggles++; ps = ifb.SCLK_o;
        if (first_t < 0) first_t = n;
        last_t = n;
      end
      if (ifb.ACKs_o != 3'b000) got = 1'b1;
    end
    ifb.REQs_i = 3'b000;
    checks++; if (!got || n != 20 || ifb.ACKs_o !== 3'b100) begin errors++; $display("FAIL h1_ack: got %0d cycles ack %b want 20/100", n, ifb.ACKs_o); end
    checks++; if (ifb.RDATs_o !== 8'hFF) begin errors++; $display("FAIL h1_rdat: got %h want ff", ifb.RDATs_o); end
    checks++; if (toggles != 16 || last_t - first_t != 15) begin errors++; $display("FAIL h1_sclk: got %0d toggles over %0d cycles want 16/15", toggles, last_t - first_t); end
  endtask

  initial begin
    int last_m;
    test_reset();
    last_m = 2;
    test_basic();
    last_m = 0;
    test_round_robin(last_m);
    test_alternate(last_m);
    test_random(last_m);
    test_cipo_isolation(last_m);
    test_reset_mid();
    test_h1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
